// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and pipeline flush.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data_in1,
  input  logic [XLEN-1:0] data_in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] data_out
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [XLEN-1:0]   opa;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;     // product, or quotient shift register in the low half
  logic [XLEN-1:0]   rem;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   result;

  // Operand decode at start
  logic            is_div, sgn1, sgn2, neg1, neg2, div_zero, ovf, special;
  logic [XLEN-1:0] mag1, mag2, special_val;

  always_comb begin
    is_div   = funct3[2];
    sgn1     = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    sgn2     = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    neg1     = sgn1 & data_in1[XLEN-1];
    neg2     = sgn2 & data_in2[XLEN-1];
    mag1     = neg1 ? -data_in1 : data_in1;
    mag2     = neg2 ? -data_in2 : data_in2;
    div_zero = is_div && (data_in2 == '0);
    ovf      = is_div && !funct3[0] && (data_in1 == {1'b1, {(XLEN-1){1'b0}}})
               && (data_in2 == '1);
    special  = div_zero || ovf;
    if (div_zero) special_val = funct3[1] ? data_in1 : '1;
    else          special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of each datapath
  logic [XLEN:0]     sum, shifted;
  logic [2*XLEN-1:0] mul_step;
  logic              ge;
  logic [XLEN-1:0]   rem_step;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    mul_step = {sum, acc[XLEN-1:1]};
    shifted  = {rem, acc[XLEN-1]};
    ge       = shifted >= {1'b0, opa};
    rem_step = ge ? XLEN'(shifted - {1'b0, opa}) : shifted[XLEN-1:0];
  end

  // Sign correction and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, fix_val;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remv = neg_r ? -rem : rem;
    case (op)
      3'b000:                 fix_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quot;
      default:                fix_val = remv;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = special ? DONE : CALC;
      CALC: if (count == CW'(ITER - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      opa      <= '0;
      acc      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_next;
      // done and data_out rise together so a flushed DONE leaves data_out intact
      done  <= (state == DONE) && !flush;
      if (state == DONE && !flush) data_out <= result;
      case (state)
        IDLE: if (start && !flush) begin
          op    <= funct3;
          opa   <= is_div ? mag2 : mag1;
          acc   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
          rem   <= '0;
          neg_q <= neg1 ^ neg2;
          neg_r <= neg1;
          count <= '0;
          if (special) result <= special_val;
        end
        CALC: begin
          count <= count + 1'b1;
          if (op[2]) begin
            rem           <= rem_step;
            acc[XLEN-1:0] <= {acc[XLEN-2:0], ge};
          end else begin
            acc <= mul_step;
          end
        end
        FIX: result <= fix_val;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, special cases, flush,
// back-to-back starts and mid-operation reset.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] data_in1, data_in2;
  logic        busy, done;
  logic [31:0] data_out;

  int n_chk = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .data_in1(data_in1), .data_in2(data_in2),
    .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; count edges after the accepting edge until done is seen.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  n;
    bit  seen;
    @(negedge clk);
    start = 1'b1; funct3 = f; data_in1 = a; data_in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":busy"}, {31'b0, busy}, 32'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, ":latency"}, n, lat);
    check({tag, ":data_out"}, data_out, exp);
    check({tag, ":busy_at_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, ":done_single"}, {31'b0, done}, 32'd0);
    check({tag, ":data_held"}, data_out, exp);
    $display("op %s f3=%0d a=%h b=%h -> %h after %0d cycles", tag, f, a, b, data_out, n);
  endtask

  initial begin
    int done_at[$];
    bit prev_done;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; data_in1 = '0; data_in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:busy", {31'b0, busy}, 32'd0);
    check("reset:done", {31'b0, done}, 32'd0);
    check("reset:data_out", data_out, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("MULH",    3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    run_op("MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("DIVU",    3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34);
    run_op("REMU",    3'b111, 32'hFFFFFFF9, 32'd2,        32'd1,        34);
    run_op("DIVU0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM0",    3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("DIVOVF",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REMOVF",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("MULWRAP", 3'b000, 32'h80000000, 32'd2,        32'd0,        34);
    run_op("DIVPOS",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);

    // Flush in the middle of CALC; data_out must keep the previous result (32'hFFFFFFF2)
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; data_in1 = 32'd3; data_in2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush:busy", {31'b0, busy}, 32'd0);
    check("flush:done", {31'b0, done}, 32'd0);
    check("flush:data_out", data_out, 32'hFFFFFFF2);
    $display("flush issued, busy=%0d done=%0d data_out=%h", busy, done, data_out);
    run_op("AFTERFLUSH", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Flush and start together in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; data_in1 = 32'd9; data_in2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start:busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("flush_start:done", {31'b0, done}, 32'd0);
    check("flush_start:data_out", data_out, 32'd12);
    $display("flush+start together, busy=%0d data_out=%h", busy, data_out);

    // start held high across three ops: done on edges 35, 70, 105 counting the first as 1
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; data_in1 = 32'd7; data_in2 = 32'hFFFFFFFD;
    prev_done = 1'b0;
    for (int k = 1; k <= 106; k++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(k);
        check("held:data_out", data_out, 32'hFFFFFFEB);
        check("held:no_double", {31'b0, prev_done}, 32'd0);
        $display("held start: done at edge %0d data_out=%h", k, data_out);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("held:count", done_at.size(), 32'd3);
    if (done_at.size() == 3) begin
      check("held:t0", done_at[0], 32'd35);
      check("held:t1", done_at[1], 32'd70);
      check("held:t2", done_at[2], 32'd105);
    end

    // Reset asserted mid-CALC
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; data_in1 = 32'd50; data_in2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst:busy", {31'b0, busy}, 32'd0);
    check("midrst:done", {31'b0, done}, 32'd0);
    check("midrst:data_out", data_out, 32'd0);
    $display("reset mid-CALC, busy=%0d done=%0d data_out=%h", busy, done, data_out);
    @(negedge clk); rst = 1'b0;
    run_op("AFTERRST", 3'b100, 32'd50, 32'd5, 32'd10, 34);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
